// File: rtl/dsc_chroma_resampler.sv
// Streaming YCbCr 4:4:4 -> 4:4:4 / 4:2:2 / 4:2:0 chroma resampler with a 1-cycle output register.
// Optional alpha pass-through is enabled by defining DSC_RESAMP_ALPHA_EN.
module dsc_chroma_resampler #(
  parameter int BPC   = 8,
  parameter int MAX_W = 1920,
  parameter int AW    = $clog2(MAX_W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     cfg_mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sof,
  input  logic           in_eol,
  input  logic [BPC-1:0] in_y,
  input  logic [BPC-1:0] in_cb,
  input  logic [BPC-1:0] in_cr,
`ifdef DSC_RESAMP_ALPHA_EN
  input  logic [BPC-1:0] in_a,
  output logic [BPC-1:0] out_a,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sof,
  output logic           out_eol,
  output logic [BPC-1:0] out_y,
  output logic [BPC-1:0] out_cb,
  output logic [BPC-1:0] out_cr,
  output logic           out_c_vld,
  output logic           err
);

  typedef enum logic [1:0] {
    MODE_444 = 2'd0,
    MODE_422 = 2'd1,
    MODE_420 = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  localparam logic [AW-1:0] X_LAST = AW'(MAX_W - 1);
  localparam int            LB_D   = MAX_W / 2;

  mode_e            r_mode;
  logic [AW-1:0]    r_x;
  logic             r_par;
  logic             r_ovf;
  logic [BPC-1:0]   r_hold_cb;
  logic [BPC-1:0]   r_hold_cr;
  logic [2*BPC-1:0] r_lbuf [LB_D];
  logic [2*BPC-1:0] r_lb_rd;

  logic             w_accept;
  mode_e            w_mode_raw;
  mode_e            w_mode;
  logic [AW-1:0]    w_x;
  logic [AW-2:0]    w_addr;
  logic             w_par;
  logic             w_ovf;
  logic [BPC:0]     w_hcb_sum;
  logic [BPC:0]     w_hcr_sum;
  logic [BPC:0]     w_vcb_sum;
  logic [BPC:0]     w_vcr_sum;
  logic [BPC-1:0]   w_h_cb;
  logic [BPC-1:0]   w_h_cr;
  logic             w_c_vld;
  logic [BPC-1:0]   w_cb;
  logic [BPC-1:0]   w_cr;
  logic             w_lb_we;
  logic             w_lb_re;
  logic             w_err_set;

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // An in_sof pixel uses the freshly presented mode and restarts position/parity in the same cycle.
  assign w_mode_raw = in_sof ? mode_e'(cfg_mode) : r_mode;
  assign w_mode     = (w_mode_raw == MODE_RSV) ? MODE_444 : w_mode_raw;
  assign w_x        = in_sof ? '0 : r_x;
  assign w_par      = in_sof ? 1'b0 : r_par;
  assign w_ovf      = in_sof ? 1'b0 : r_ovf;
  assign w_addr     = w_x[AW-1:1];

  assign w_hcb_sum = {1'b0, r_hold_cb} + {1'b0, in_cb} + (BPC+1)'(1);
  assign w_hcr_sum = {1'b0, r_hold_cr} + {1'b0, in_cr} + (BPC+1)'(1);
  assign w_h_cb    = w_hcb_sum[BPC:1];
  assign w_h_cr    = w_hcr_sum[BPC:1];
  assign w_vcb_sum = {1'b0, r_lb_rd[2*BPC-1:BPC]} + {1'b0, w_h_cb} + (BPC+1)'(1);
  assign w_vcr_sum = {1'b0, r_lb_rd[BPC-1:0]} + {1'b0, w_h_cr} + (BPC+1)'(1);

  // NOTE: every signal written here gets a default first so no latch is inferred on any path.
  always_comb begin
    w_c_vld = 1'b0;
    w_cb    = '0;
    w_cr    = '0;
    w_lb_we = 1'b0;
    w_lb_re = 1'b0;
    case (w_mode)
      MODE_422, MODE_420: begin
        if (w_ovf) begin
          w_c_vld = 1'b0;
        end else if (!w_x[0] && in_eol) begin
          w_c_vld = 1'b1;
          w_cb    = in_cb;
          w_cr    = in_cr;
        end else if (w_x[0]) begin
          if (w_mode == MODE_422) begin
            w_c_vld = 1'b1;
            w_cb    = w_h_cb;
            w_cr    = w_h_cr;
          end else if (!w_par) begin
            w_lb_we = 1'b1;
          end else begin
            w_c_vld = 1'b1;
            w_cb    = w_vcb_sum[BPC:1];
            w_cr    = w_vcr_sum[BPC:1];
          end
        end else begin
          // Fetch the upper-line pair one pixel early so the odd pixel sees registered data.
          w_lb_re = (w_mode == MODE_420) && w_par;
        end
      end
      default: begin
        w_c_vld = 1'b1;
        w_cb    = in_cb;
        w_cr    = in_cr;
      end
    endcase
  end

  assign w_err_set = (in_sof && (cfg_mode == MODE_RSV))
                   || (in_eol && !w_x[0] && !w_ovf)
                   || (!in_eol && (w_x == X_LAST));

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_y     <= '0;
      out_cb    <= '0;
      out_cr    <= '0;
      out_c_vld <= 1'b0;
`ifdef DSC_RESAMP_ALPHA_EN
      out_a     <= '0;
`endif
      err       <= 1'b0;
      r_mode    <= MODE_444;
      r_x       <= '0;
      r_par     <= 1'b0;
      r_ovf     <= 1'b0;
      r_hold_cb <= '0;
      r_hold_cr <= '0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out_sof   <= in_sof;
      out_eol   <= in_eol;
      out_y     <= in_y;
      out_cb    <= w_cb;
      out_cr    <= w_cr;
      out_c_vld <= w_c_vld;
`ifdef DSC_RESAMP_ALPHA_EN
      out_a     <= in_a;
`endif
      err       <= err | w_err_set;
      if (in_sof) r_mode <= mode_e'(cfg_mode);
      if (!w_x[0]) begin
        r_hold_cb <= in_cb;
        r_hold_cr <= in_cr;
      end
      if (in_eol) begin
        r_x   <= '0;
        r_ovf <= 1'b0;
        r_par <= !w_par;
      end else begin
        r_par <= w_par;
        if (w_x == X_LAST) begin
          r_x   <= w_x;
          r_ovf <= 1'b1;
        end else begin
          r_x   <= w_x + 1'b1;
          r_ovf <= w_ovf;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // NOTE: the line buffer and its read register carry no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (w_accept && w_lb_we) r_lbuf[w_addr] <= {w_h_cb, w_h_cr};
    if (w_accept && w_lb_re) r_lb_rd <= r_lbuf[w_addr];
  end

endmodule

// File: tb/tb_dsc_chroma_resampler.sv
// Directed self-checking bench for dsc_chroma_resampler (BPC=8, MAX_W=1920).
module tb_dsc_chroma_resampler;

  localparam int BPC   = 8;
  localparam int MAX_W = 1920;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     cfg_mode = 2'd0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_sof = 1'b0;
  logic           in_eol = 1'b0;
  logic [BPC-1:0] in_y = '0;
  logic [BPC-1:0] in_cb = '0;
  logic [BPC-1:0] in_cr = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_sof;
  logic           out_eol;
  logic [BPC-1:0] out_y;
  logic [BPC-1:0] out_cb;
  logic [BPC-1:0] out_cr;
  logic           out_c_vld;
  logic           err;
`ifdef DSC_RESAMP_ALPHA_EN
  logic [BPC-1:0] in_a = '0;
  logic [BPC-1:0] out_a;
`endif

  int checks   = 0;
  int failures = 0;
  bit bp_en    = 1'b0;

  typedef struct {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       cvld;
    logic       sof;
    logic       eol;
  } obs_t;

  obs_t mon_q[$];

  dsc_chroma_resampler #(.BPC(BPC), .MAX_W(MAX_W)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_eol(in_eol),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
`ifdef DSC_RESAMP_ALPHA_EN
    .in_a(in_a), .out_a(out_a),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr), .out_c_vld(out_c_vld), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so values seen at negedge are those the next posedge samples.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready)
        mon_q.push_back('{y: out_y, cb: out_cb, cr: out_cr, cvld: out_c_vld, sof: out_sof, eol: out_eol});
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic drive_px(input logic sof, input logic eol, input logic [7:0] y,
                          input logic [7:0] cb, input logic [7:0] cr);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_sof = sof; in_eol = eol; in_y = y; in_cb = cb; in_cr = cr;
    n = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 1000) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, required an accept", n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_eol = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_c_vld !== 1'b0 || out_y !== 8'd0 || out_cb !== 8'd0
        || out_sof !== 1'b0 || out_eol !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: valid=%b cvld=%b y=%0d cb=%0d err=%b in_ready=%b, required 0 0 0 0 0 1",
               out_valid, out_c_vld, out_y, out_cb, err, in_ready);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_444();
    cfg_mode = 2'd0;
    mon_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive_px(i == 0, i == 3, 8'(10 * (i + 1)), 8'd100, 8'd100);
      checks++;
      if (out_valid !== 1'b1 || out_y !== 8'(10 * (i + 1)) || out_cb !== 8'd100
          || out_cr !== 8'd100 || out_c_vld !== 1'b1) begin
        failures++;
        $display("FAIL p444_latency px%0d: valid=%b y=%0d cb=%0d cr=%0d cvld=%b, required 1 %0d 100 100 1",
                 i, out_valid, out_y, out_cb, out_cr, out_c_vld, 10 * (i + 1));
      end
    end
    idle(2);
    checks++;
    if (mon_q.size() != 4 || !mon_q[0].sof || !mon_q[3].eol || mon_q[1].sof || mon_q[2].eol) begin
      failures++;
      $display("FAIL p444_markers: count=%0d, required 4 with sof on first and eol on last", mon_q.size());
    end
  endtask

  task automatic test_422();
    logic [7:0] cb_i [4]  = '{8'd100, 8'd201, 8'd50, 8'd51};
    logic [7:0] cr_i [4]  = '{8'd0, 8'd255, 8'd255, 8'd0};
    logic       exp_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_cb [4] = '{8'd0, 8'd151, 8'd0, 8'd51};
    logic [7:0] exp_cr [4] = '{8'd0, 8'd128, 8'd0, 8'd128};
    mon_q.delete();
    cfg_mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      drive_px(i == 0, i == 3, 8'(i + 1), cb_i[i], cr_i[i]);
      cfg_mode = 2'd0;
    end
    idle(2);
    checks++;
    if (mon_q.size() != 4) begin
      failures++;
      $display("FAIL p422_count: got %0d outputs, required 4", mon_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mon_q[i].cvld !== exp_v[i] || mon_q[i].cb !== exp_cb[i] || mon_q[i].cr !== exp_cr[i]
            || mon_q[i].y !== 8'(i + 1)) begin
          failures++;
          $display("FAIL p422 px%0d: cvld=%b cb=%0d cr=%0d y=%0d, required %b %0d %0d %0d",
                   i, mon_q[i].cvld, mon_q[i].cb, mon_q[i].cr, mon_q[i].y,
                   exp_v[i], exp_cb[i], exp_cr[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_420();
    logic [7:0] cb_i [8]  = '{8'd10, 8'd10, 8'd20, 8'd20, 8'd30, 8'd30, 8'd41, 8'd41};
    logic [7:0] cr_i [8]  = '{8'd11, 8'd11, 8'd21, 8'd21, 8'd31, 8'd31, 8'd42, 8'd42};
    logic       exp_v [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_cb [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20, 8'd0, 8'd31};
    logic [7:0] exp_cr [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd21, 8'd0, 8'd32};
    mon_q.delete();
    cfg_mode = 2'd2;
    for (int i = 0; i < 8; i++)
      drive_px(i == 0, (i % 4) == 3, 8'(i), cb_i[i], cr_i[i]);
    idle(2);
    checks++;
    if (mon_q.size() != 8) begin
      failures++;
      $display("FAIL p420_count: got %0d outputs, required 8", mon_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (mon_q[i].cvld !== exp_v[i] || mon_q[i].cb !== exp_cb[i] || mon_q[i].cr !== exp_cr[i]) begin
          failures++;
          $display("FAIL p420 px%0d: cvld=%b cb=%0d cr=%0d, required %b %0d %0d",
                   i, mon_q[i].cvld, mon_q[i].cb, mon_q[i].cr, exp_v[i], exp_cb[i], exp_cr[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cb_a [MAX_W];
    logic [7:0] cr_a [MAX_W];
    int bad;
    int first_bad;
    logic [8:0] s;
    logic       ev;
    logic [7:0] ecb;
    logic [7:0] ecr;
    for (int i = 0; i < MAX_W; i++) begin
      cb_a[i] = 8'((i * 7) & 255);
      cr_a[i] = 8'((i * 13 + 5) & 255);
    end
    mon_q.delete();
    cfg_mode = 2'd1;
    bp_en = 1'b1;
    for (int i = 0; i < MAX_W; i++)
      drive_px(i == 0, i == MAX_W - 1, 8'(i), cb_a[i], cr_a[i]);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    bp_en = 1'b0;
    #1;
    out_ready = 1'b1;
    idle(3);
    checks++;
    if (mon_q.size() != MAX_W) begin
      failures++;
      $display("FAIL bp_count: got %0d outputs, required %0d", mon_q.size(), MAX_W);
    end else begin
      bad = 0;
      first_bad = -1;
      for (int i = 0; i < MAX_W; i++) begin
        ev = 1'b0; ecb = 8'd0; ecr = 8'd0;
        if (i % 2 == 1) begin
          ev = 1'b1;
          s = {1'b0, cb_a[i-1]} + {1'b0, cb_a[i]} + 9'd1; ecb = s[8:1];
          s = {1'b0, cr_a[i-1]} + {1'b0, cr_a[i]} + 9'd1; ecr = s[8:1];
        end
        if (mon_q[i].y !== 8'(i) || mon_q[i].cvld !== ev || mon_q[i].cb !== ecb || mon_q[i].cr !== ecr) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL bp_sequence: %0d pixels differ from model, first at index %0d, required 0", bad, first_bad);
      end
    end
  endtask

  task automatic test_odd_width();
    logic [7:0] cb_i [3]  = '{8'd60, 8'd80, 8'd90};
    logic [7:0] cr_i [3]  = '{8'd10, 8'd20, 8'd30};
    logic       exp_v [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] exp_cb [3] = '{8'd0, 8'd70, 8'd90};
    logic [7:0] exp_cr [3] = '{8'd0, 8'd15, 8'd30};
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clean_before_odd: err=%b, required 0", err);
    end
    mon_q.delete();
    cfg_mode = 2'd1;
    for (int i = 0; i < 3; i++)
      drive_px(i == 0, i == 2, 8'(i), cb_i[i], cr_i[i]);
    idle(2);
    checks++;
    if (mon_q.size() != 3) begin
      failures++;
      $display("FAIL odd_count: got %0d outputs, required 3", mon_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (mon_q[i].cvld !== exp_v[i] || mon_q[i].cb !== exp_cb[i] || mon_q[i].cr !== exp_cr[i]) begin
          failures++;
          $display("FAIL odd px%0d: cvld=%b cb=%0d cr=%0d, required %b %0d %0d",
                   i, mon_q[i].cvld, mon_q[i].cb, mon_q[i].cr, exp_v[i], exp_cb[i], exp_cr[i]);
        end
      end
    end
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL odd_err: err=%b, required 1", err);
    end
    cfg_mode = 2'd0;
    drive_px(1'b1, 1'b0, 8'd1, 8'd2, 8'd3);
    drive_px(1'b0, 1'b1, 8'd4, 8'd5, 8'd6);
    idle(2);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b after clean frame, required 1", err);
    end
  endtask

  task automatic test_reset_midline();
    mon_q.delete();
    cfg_mode = 2'd2;
    for (int i = 0; i < 4; i++)
      drive_px(i == 0, i == 3, 8'(i), 8'd40, 8'd40);
    drive_px(1'b0, 1'b0, 8'd99, 8'd50, 8'd50);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_y !== 8'd0 || out_c_vld !== 1'b0 || out_cb !== 8'd0
        || err !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midline_reset: valid=%b y=%0d cvld=%b cb=%0d err=%b in_ready=%b, required 0 0 0 0 0 1",
               out_valid, out_y, out_c_vld, out_cb, err, in_ready);
    end
    rst = 1'b0;
    idle(1);
    mon_q.delete();
    cfg_mode = 2'd2;
    for (int i = 0; i < 4; i++)
      drive_px(i == 0, i == 3, 8'(i), 8'(20 + i), 8'(30 + i));
    idle(2);
    checks++;
    if (mon_q.size() != 4 || mon_q[0].cvld || mon_q[1].cvld || mon_q[2].cvld || mon_q[3].cvld) begin
      failures++;
      $display("FAIL post_reset_even_line: count=%0d with some cvld set, required 4 outputs all cvld=0",
               mon_q.size());
    end
  endtask

  task automatic test_mode3();
    mon_q.delete();
    cfg_mode = 2'd3;
    drive_px(1'b1, 1'b0, 8'd1, 8'd77, 8'd66);
    drive_px(1'b0, 1'b1, 8'd2, 8'd88, 8'd55);
    idle(2);
    checks++;
    if (mon_q.size() != 2 || !mon_q[0].cvld || !mon_q[1].cvld || mon_q[0].cb !== 8'd77
        || mon_q[1].cb !== 8'd88 || mon_q[1].cr !== 8'd55) begin
      failures++;
      $display("FAIL mode3_as_444: count=%0d, required 2 outputs passed through with cvld=1", mon_q.size());
    end
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL mode3_err: err=%b, required 1", err);
    end
  endtask

  task automatic test_overflow();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    mon_q.delete();
    cfg_mode = 2'd1;
    for (int i = 0; i < MAX_W + 2; i++) begin
      drive_px(i == 0, i == MAX_W + 1, 8'(i), 8'(i * 3), 8'(i * 5));
      if (i == MAX_W - 2) begin
        checks++;
        if (err !== 1'b0) begin
          failures++;
          $display("FAIL ovf_err_early: err=%b at x=%0d, required 0", err, i);
        end
      end
      if (i == MAX_W - 1) begin
        checks++;
        if (err !== 1'b1) begin
          failures++;
          $display("FAIL ovf_err: err=%b after x reached MAX_W, required 1", err);
        end
      end
    end
    idle(2);
    checks++;
    if (mon_q.size() != MAX_W + 2 || !mon_q[MAX_W-1].cvld || mon_q[MAX_W].cvld || mon_q[MAX_W+1].cvld) begin
      failures++;
      $display("FAIL ovf_chroma: count=%0d, required %0d with cvld 1,0,0 on the last three",
               mon_q.size(), MAX_W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_444();
    test_422();
    test_420();
    test_back_to_back();
    test_odd_width();
    test_reset_midline();
    test_mode3();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
